// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode constants, and the ALU / PC mux select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_WB_MEM   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12,
        ST_ERROR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_source_t;

    // True when the opcode is one this controller knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op, input logic has_imm);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            OP_ADDI, OP_ANDI:                     ok = has_imm;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_control_mem_wait_timer.sv
// Counts consecutive unready cycles of a memory access and flags the cycle
// on which the tolerated number of waits runs out. One instance serves the
// fetch, load and store states since only one access is ever in flight.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expire
);
    import mc_ctrl_pkg::*;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Wait counter: restarts on entry to a memory state, saturates so a
    // disabled timeout never wraps back into a misleading small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (active && !ready && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    // Expiry fires on the last tolerated unready cycle; a ready in that same
    // cycle suppresses it so the access completes normally.
    always_comb begin
        expire = (TIMEOUT != 0) && active && !ready && (count == LAST);
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control: a Moore FSM that walks each MIPS instruction
// through fetch/decode/execute/memory/writeback, stalls on the cache ready
// handshake, traps a dead memory into ERROR, and counts retirements.
module mc_control #(
    parameter int HAS_IMM = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             illegal,
    output logic             err,
    output logic [3:0]       state
);
    import mc_ctrl_pkg::*;

    localparam logic IMM_EN = (HAS_IMM != 0);

    state_t     cur_state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       wait_active;
    logic       wait_clear;
    logic       wait_expire;

    // State register; reset lands in IDLE so all controls drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Opcode is captured in DECODE so later steps do not depend on IR timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (cur_state == ST_DECODE) begin
            op_q <= opcode;
        end
    end

    // Retirement counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Memory states share one wait timer; it restarts only when a memory
    // state is newly entered, not while stalling inside one.
    always_comb begin
        wait_active = (cur_state == ST_FETCH) || (cur_state == ST_MEM_RD) ||
                      (cur_state == ST_MEM_WR);
        wait_clear  = ((next_state == ST_FETCH) || (next_state == ST_MEM_RD) ||
                       (next_state == ST_MEM_WR)) && (next_state != cur_state);
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wait_clear),
        .active (wait_active),
        .ready  (mem_ready),
        .expire (wait_expire)
    );

    // Next-state and Moore control decode; mem_ready only gates the
    // fetch/store completion strobes.
    always_comb begin
        next_state    = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        retire        = 1'b0;
        err           = 1'b0;

        case (cur_state)
            ST_IDLE: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = ST_DECODE;
                end else if (wait_expire) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:         next_state = ST_R_EXEC;
                    OP_LW, OP_SW:     next_state = ST_MEM_ADDR;
                    OP_BEQ:           next_state = ST_BRANCH;
                    OP_J:             next_state = ST_JUMP;
                    OP_ADDI, OP_ANDI: next_state = IMM_EN ? ST_I_EXEC : ST_FETCH;
                    default:          next_state = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = ST_WB_MEM;
                end else if (wait_expire) begin
                    next_state = ST_ERROR;
                end
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                if (mem_ready) begin
                    next_state = ST_FETCH;
                end else if (wait_expire) begin
                    next_state = ST_ERROR;
                end
            end
            ST_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                next_state = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                retire        = 1'b1;
                next_state    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_JUMP;
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = (op_q == OP_ANDI) ? ALU_AND : ALU_ADD;
                next_state = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Illegal-opcode flag looks at the live opcode while decoding.
    always_comb begin
        illegal = (cur_state == ST_DECODE) && !op_legal(opcode, IMM_EN);
    end

    assign state = cur_state;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle successor to the single-cycle main control decoder. A Moore FSM sequences each MIPS instruction (R-type, lw, sw, beq, j, and optionally addi/andi) through fetch, decode, execute, memory and writeback steps. It stalls on a cache ready handshake, times out on a dead memory, and counts retired instructions. It sits between the instruction register / cache and the shared-ALU multi-cycle datapath.

## Interface
Parameters:
- `HAS_IMM`, 1: 1 enables addi (`001000`) and andi (`001100`); 0 makes them illegal.
- `TIMEOUT`, 16: consecutive unready cycles tolerated in any memory state; 0 disables the timeout.
- `CNT_W`, 32: width of the retire counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `mem_ready` in 1: cache completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` out 1: datapath controls.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct, 11 = and.
- `pc_source` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `retire_cnt` out CNT_W: retired-instruction count.
- `illegal` out 1: unsupported opcode in DECODE.
- `err` out 1: sticky memory timeout.
- `state` out 4: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB, ERROR.
- **IDLE**: all controls 0. Goes to FETCH next cycle.
- **FETCH**: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- **DECODE**: alu_src_b=11, alu_op=00. Latches `opcode` into `op_q`.
  - `000000` → R_EXEC, `100011`/`101011` → MEM_ADDR, `000100` → BRANCH, `000010` → JUMP.
  - addi/andi → I_EXEC only when HAS_IMM=1.
  - Any other opcode: illegal=1 this cycle, next state FETCH, not retired.
- **MEM_ADDR**: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD (lw) or MEM_WR (sw) based on op_q.
- **MEM_RD**: mem_read=1, i_or_d=1. On mem_ready go to WB_MEM.
- **WB_MEM**: reg_write=1, mem_to_reg=1, reg_dst=0. Retires.
- **MEM_WR**: mem_write=1, i_or_d=1. Retires on mem_ready, then goes to FETCH.
- **R_EXEC**: alu_src_a=1, alu_src_b=00, alu_op=10.
- **R_WB**: reg_write=1, reg_dst=1. Retires.
- **BRANCH**: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires.
- **JUMP**: pc_write=1, pc_source=10. Retires.
- **I_EXEC**: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for andi.
- **I_WB**: reg_write=1, reg_dst=0. Retires.
- Every retiring state returns to FETCH.
- **ERROR**: all controls 0, err=1. Absorbing until reset.
- Any control not listed for a state is 0.

## Timing
- Reset: state=IDLE; every output 0; retire_cnt=0, wait counter=0, err=0.
- Reset mid-access drops mem_read/mem_write on the same asynchronous assertion.
- Zero-wait latency, from FETCH entry to retire cycle inclusive:
  - 3 cycles: j, beq.
  - 4 cycles: R-type, addi, andi, sw.
  - 5 cycles: lw.
  - Each unready cycle in a memory state adds 1.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on each unready cycle.
  - When TIMEOUT≠0 and the TIMEOUT-th consecutive unready cycle occurs, next state is ERROR.
  - mem_ready on that same cycle wins: the access proceeds normally.
- mem_read/mem_write stay asserted and stable for the whole wait.
- retire_cnt increments in the cycle after the retire pulse and wraps at 2^CNT_W-1 → 0.
- `illegal` is combinational from state and opcode; all other outputs decode from registered state, plus mem_ready where stated.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI);
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, `mem_wait_timer`: clear, count and expire logic, parameterised by TIMEOUT. It is shared by all three memory states.

## Test plan
- Reset, then R-type with mem_ready held at 1 → states IDLE, FETCH, DECODE, R_EXEC, R_WB; retire on cycle 5 after reset release; retire_cnt=1.
- lw with FETCH ready delayed 2 cycles and MEM_RD ready delayed 1 → 8 cycles from FETCH to retire; ir_write high in exactly one cycle; mem_read stable throughout.
- sw, beq, j back-to-back with zero wait → retire_cnt=3 after 10 cycles; pc_write_cond only in BRANCH; pc_source=10 only in JUMP.
- HAS_IMM=0 with addi opcode → illegal=1 in DECODE, no reg_write, return to FETCH, retire_cnt unchanged. HAS_IMM=1 → andi gives alu_op=11 in I_EXEC.
- TIMEOUT=4 with mem_ready stuck at 0 → 4 FETCH cycles, then ERROR with err=1, held until rst_n low. Same setup with ready on the 4th cycle → DECODE, no error.
- rst_n asserted during MEM_RD wait → mem_read drops to 0 immediately; state=IDLE; retire_cnt=0; next fetch proceeds normally.
